// File: rtl/ex_operand_alu.sv
// Execute-stage operand forwarding, ALU and EX/MEM result/store-data register.
// The forwarding select codes come from an external unit; this block only muxes.
module ex_operand_alu #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] reg1_data,
  input  logic [DATA_W-1:0] reg2_data,
  input  logic [DATA_W-1:0] immediate,
  input  logic              alu_src,
  input  logic [1:0]        forward_a,
  input  logic [1:0]        forward_b,
  input  logic [DATA_W-1:0] ex_mem_data,
  input  logic [DATA_W-1:0] mem_wb_data,
  input  logic [3:0]        alu_cmd,
  output logic [DATA_W-1:0] alu_res,
  output logic              alu_zero,
  output logic [DATA_W-1:0] alu_out_q,
  output logic [DATA_W-1:0] store_data_q
);

  localparam logic [3:0] CMD_ADD  = 4'd0;
  localparam logic [3:0] CMD_SUB  = 4'd1;
  localparam logic [3:0] CMD_AND  = 4'd2;
  localparam logic [3:0] CMD_OR   = 4'd3;
  localparam logic [3:0] CMD_XOR  = 4'd4;
  localparam logic [3:0] CMD_NOR  = 4'd5;
  localparam logic [3:0] CMD_SLT  = 4'd6;
  localparam logic [3:0] CMD_SLTU = 4'd7;
  localparam logic [3:0] CMD_SLL  = 4'd8;
  localparam logic [3:0] CMD_SRL  = 4'd9;
  localparam logic [3:0] CMD_SRA  = 4'd10;
  localparam logic [3:0] CMD_LUI  = 4'd11;

  // Select code 2'b11 falls back to register data so the mux never yields X.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] reg_v,
    input logic [DATA_W-1:0] exm_v,
    input logic [DATA_W-1:0] mwb_v
  );
    case (sel)
      2'b10:   return exm_v;
      2'b01:   return mwb_v;
      default: return reg_v;
    endcase
  endfunction

  // ---- Stage p0: operand selection and combinational ALU ----
  logic        [DATA_W-1:0] opa_p0;
  logic        [DATA_W-1:0] fwd_b_p0;
  logic        [DATA_W-1:0] opb_p0;
  logic signed [DATA_W-1:0] opa_s_p0;
  logic signed [DATA_W-1:0] opb_s_p0;
  logic        [4:0]        shamt_p0;

  assign opa_p0   = fwd_sel(forward_a, reg1_data, ex_mem_data, mem_wb_data);
  assign fwd_b_p0 = fwd_sel(forward_b, reg2_data, ex_mem_data, mem_wb_data);
  assign opb_p0   = alu_src ? immediate : fwd_b_p0;
  assign opa_s_p0 = opa_p0;
  assign opb_s_p0 = opb_p0;
  assign shamt_p0 = opa_p0[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_cmd)
      CMD_ADD:  alu_res = opa_p0 + opb_p0;
      CMD_SUB:  alu_res = opa_p0 - opb_p0;
      CMD_AND:  alu_res = opa_p0 & opb_p0;
      CMD_OR:   alu_res = opa_p0 | opb_p0;
      CMD_XOR:  alu_res = opa_p0 ^ opb_p0;
      CMD_NOR:  alu_res = ~(opa_p0 | opb_p0);
      CMD_SLT:  alu_res = {{(DATA_W-1){1'b0}}, (opa_s_p0 < opb_s_p0)};
      CMD_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (opa_p0 < opb_p0)};
      CMD_SLL:  alu_res = opb_p0 << shamt_p0;
      CMD_SRL:  alu_res = opb_p0 >> shamt_p0;
      CMD_SRA:  alu_res = opb_s_p0 >>> shamt_p0;
      CMD_LUI:  alu_res = DATA_W'({opb_p0[15:0], 16'h0000});
      default:  alu_res = '0;
    endcase
  end

  assign alu_zero = (alu_res == '0);

  // ---- Stage p1: EX/MEM boundary register; store data is always the forwarded rt ----
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_q    <= '0;
      store_data_q <= '0;
    end else begin
      alu_out_q    <= alu_res;
      store_data_q <= fwd_b_p0;
    end
  end

endmodule

// File: tb/tb_ex_operand_alu.sv
// Directed bench for ex_operand_alu: reset, forwarding, immediate path,
// compares, logic ops, shifts, LUI, wrap-around and undefined commands.
module tb_ex_operand_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] reg1_data, reg2_data, immediate, ex_mem_data, mem_wb_data;
  logic        alu_src;
  logic [1:0]  forward_a, forward_b;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_res, alu_out_q, store_data_q;
  logic        alu_zero;

  int tests  = 0;
  int failed = 0;

  ex_operand_alu #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .reg1_data    (reg1_data),
    .reg2_data    (reg2_data),
    .immediate    (immediate),
    .alu_src      (alu_src),
    .forward_a    (forward_a),
    .forward_b    (forward_b),
    .ex_mem_data  (ex_mem_data),
    .mem_wb_data  (mem_wb_data),
    .alu_cmd      (alu_cmd),
    .alu_res      (alu_res),
    .alu_zero     (alu_zero),
    .alu_out_q    (alu_out_q),
    .store_data_q (store_data_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; reg1_data = 32'd5; reg2_data = 32'd7; immediate = '0;
    ex_mem_data = '0; mem_wb_data = '0; alu_src = 1'b0;
    forward_a = 2'b00; forward_b = 2'b00; alu_cmd = 4'd0;

    // Reset and release
    tick();
    check("rst_alu_out_q", alu_out_q, 32'd0);
    check("rst_store_q", store_data_q, 32'd0);
    check("rst_comb_res", alu_res, 32'd12);
    rst = 1'b0;
    tick();
    check("rel_alu_out_q", alu_out_q, 32'd12);
    check("rel_store_q", store_data_q, 32'd7);

    // Forwarding
    reg1_data = 32'd1; reg2_data = 32'd3; ex_mem_data = 32'd100; mem_wb_data = 32'd200;
    forward_a = 2'b10; forward_b = 2'b01;
    #1;
    check("fwd_res_300", alu_res, 32'd300);
    check("fwd_zero_0", {31'd0, alu_zero}, 32'd0);
    tick();
    check("fwd_alu_out_q", alu_out_q, 32'd300);
    check("fwd_store_q", store_data_q, 32'd200);
    forward_a = 2'b11;
    #1 check("fwd_a11_res", alu_res, 32'd201);
    forward_b = 2'b11;
    #1 check("fwd_ab11_res", alu_res, 32'd4);
    forward_a = 2'b10; forward_b = 2'b10;
    #1 check("fwd_same_exm", alu_res, 32'd200);
    forward_a = 2'b01; forward_b = 2'b01;
    #1 check("fwd_same_mwb", alu_res, 32'd400);

    // Immediate path: store data still forwarded
    alu_src = 1'b1; immediate = 32'hFFFF_FFFC; reg1_data = 32'd10;
    forward_a = 2'b00; forward_b = 2'b10; ex_mem_data = 32'd9;
    #1 check("imm_res", alu_res, 32'd6);
    tick();
    check("imm_alu_out_q", alu_out_q, 32'd6);
    check("imm_store_q", store_data_q, 32'd9);

    // Signed vs unsigned compare, SUB to zero
    alu_src = 1'b0; forward_a = 2'b00; forward_b = 2'b00;
    reg1_data = 32'hFFFF_FFFF; reg2_data = 32'd1; alu_cmd = 4'd6;
    #1 check("slt", alu_res, 32'd1);
    alu_cmd = 4'd7;
    #1 check("sltu", alu_res, 32'd0);
    reg1_data = 32'h55; reg2_data = 32'h55; alu_cmd = 4'd1;
    #1 check("sub_eq_res", alu_res, 32'd0);
    check("sub_eq_zero", {31'd0, alu_zero}, 32'd1);
    reg1_data = 32'd3; reg2_data = 32'd5;
    #1 check("sub_wrap", alu_res, 32'hFFFF_FFFE);

    // Logic ops
    reg1_data = 32'hF0F0_00FF; reg2_data = 32'h0FF0_0F0F;
    alu_cmd = 4'd2; #1 check("and", alu_res, 32'h00F0_000F);
    alu_cmd = 4'd3; #1 check("or",  alu_res, 32'hFFF0_0FFF);
    alu_cmd = 4'd4; #1 check("xor", alu_res, 32'hFF00_0FF0);
    alu_cmd = 4'd5; #1 check("nor", alu_res, 32'h000F_F000);

    // Shifts (upper opa bits must be ignored) and LUI
    reg1_data = 32'd4; reg2_data = 32'h8000_00F0;
    alu_cmd = 4'd8;  #1 check("sll", alu_res, 32'h0000_0F00);
    alu_cmd = 4'd9;  #1 check("srl", alu_res, 32'h0800_000F);
    alu_cmd = 4'd10; #1 check("sra", alu_res, 32'hF800_000F);
    reg1_data = 32'hFFFF_FFE4;
    #1 check("sra_upper_ign", alu_res, 32'hF800_000F);
    alu_cmd = 4'd8;  #1 check("sll_upper_ign", alu_res, 32'h0000_0F00);
    reg2_data = 32'h0000_1234; alu_cmd = 4'd11;
    #1 check("lui", alu_res, 32'h1234_0000);

    // Wrap and undefined commands
    reg1_data = 32'hFFFF_FFFF; reg2_data = 32'd1; alu_cmd = 4'd0;
    #1 check("add_wrap", alu_res, 32'd0);
    check("add_wrap_zero", {31'd0, alu_zero}, 32'd1);
    reg1_data = 32'h1234_5678; reg2_data = 32'h0BAD_F00D; alu_cmd = 4'd13;
    #1 check("cmd13", alu_res, 32'd0);
    alu_cmd = 4'd15;
    #1 check("cmd15", alu_res, 32'd0);

    // Mid-stream reset
    reg1_data = 32'd3; reg2_data = 32'd4; alu_cmd = 4'd0;
    tick();
    check("pre_rst_out_q", alu_out_q, 32'd7);
    check("pre_rst_store_q", store_data_q, 32'd4);
    rst = 1'b1;
    tick();
    check("mid_rst_out_q", alu_out_q, 32'd0);
    check("mid_rst_store_q", store_data_q, 32'd0);
    check("mid_rst_comb", alu_res, 32'd7);
    rst = 1'b0;
    tick();
    check("post_rst_out_q", alu_out_q, 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
